// File: rtl/lis3dh_sampler.sv
// lis3dh_sampler
// Register-port sequencer in front of an 8-bit SPI master core. After reset it
// writes CTRL_REG1 of a LIS3DH accelerometer. It then periodically burst-reads
// OUT_X_L..OUT_Z_H and publishes signed 16-bit X/Y/Z samples.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset (shared with core)
//   enable            level, permits sample bursts
//   mem_addr          core register address (0 rxdata, 1 txdata, 3 control)
//   data_from_cpu     core write data
//   read_n, write_n   core strobes, active low
//   spi_select        core chip select
//   data_to_cpu       core read data (registered inside the core)
//   readyfordata      core TRDY
//   dataavailable     core RRDY
//   sample_x/y/z      last published samples, {H,L}
//   sample_valid      one-cycle pulse when all three samples update
//   cfg_done          sticky, high once the CTRL_REG1 write has completed
//   busy              high while a sample burst is in progress
//   error             sticky wait-timeout flag, cleared only by reset
//   dbg_state         current FSM state encoding
//
// Bus access handshake: spi_select=1 with exactly one of read_n/write_n low for
// exactly two cycles, mem_addr/data_from_cpu stable throughout. This is
// followed by at least one cycle with all strobes idle. Read data is taken from
// data_to_cpu on the clock edge that ends the second strobe cycle.
module lis3dh_sampler #(
  parameter int unsigned SAMPLE_DIV = 800000,
  parameter logic [7:0]  CTRL1_VAL  = 8'h57,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [2:0]  mem_addr,
  output logic [15:0] data_from_cpu,
  output logic        read_n,
  output logic        write_n,
  output logic        spi_select,
  input  logic [15:0] data_to_cpu,
  input  logic        readyfordata,
  input  logic        dataavailable,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  output logic        cfg_done,
  output logic        busy,
  output logic        error,
  output logic [3:0]  dbg_state
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT);

  typedef enum logic [3:0] {
    S_CFG, S_IDLE, S_SS_ON, S_WAIT_TX, S_WR_TX, S_WAIT_RX, S_RD_RX, S_SS_OFF, S_PUBLISH
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ph_q, ph_d;           // access phase: 0,1 strobe, 2 idle
  logic [2:0]       byte_q, byte_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_mode_q, cfg_mode_d; // current sequence is the config write
  logic             tmo_q, tmo_d;           // current sequence hit a timeout
  logic [5:0][7:0]  rx_q, rx_d;

  logic [2:0]  mem_addr_q, mem_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        read_n_q, read_n_d, write_n_q, write_n_d, sel_q, sel_d;
  logic [15:0] sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic        valid_q, valid_d, cfg_done_q, cfg_done_d, busy_q, busy_d, error_q, error_d;

  logic        tick, last_byte, acc_d;
  logic [7:0]  tx_byte;

  // The core returns one byte per transfer; the upper half carries nothing.
  logic unused_rx_hi;
  assign unused_rx_hi = ^data_to_cpu[15:8];

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    byte_d     = byte_q;
    to_d       = to_q;
    cfg_mode_d = cfg_mode_q;
    tmo_d      = tmo_q;
    rx_d       = rx_q;
    cfg_done_d = cfg_done_q;
    error_d    = error_q;

    // Period counter free-runs once configured; ticks arriving outside IDLE are lost.
    tick  = cfg_done_q && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (cfg_done_q) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    last_byte = cfg_mode_q ? (byte_q == 3'd1) : (byte_q == 3'd6);

    case (state_q)
      S_CFG: begin
        // One settle cycle so the first access starts two cycles after reset.
        if (ph_q == 2'd0) begin
          ph_d = 2'd1;
        end else begin
          ph_d       = 2'd0;
          cfg_mode_d = 1'b1;
          tmo_d      = 1'b0;
          byte_d     = 3'd0;
          state_d    = S_SS_ON;
        end
      end
      S_IDLE: begin
        if (tick && enable) begin
          ph_d       = 2'd0;
          cfg_mode_d = 1'b0;
          tmo_d      = 1'b0;
          byte_d     = 3'd0;
          state_d    = S_SS_ON;
        end
      end
      S_SS_ON, S_WR_TX, S_RD_RX, S_SS_OFF: begin
        // Received byte 0 is the dummy clocked out with the address byte.
        if (state_q == S_RD_RX && ph_q == 2'd1 && !cfg_mode_q && byte_q != 3'd0)
          rx_d[byte_q - 3'd1] = data_to_cpu[7:0];
        if (ph_q != 2'd2) begin
          ph_d = ph_q + 2'd1;
        end else begin
          ph_d = 2'd0;
          to_d = '0;
          if (state_q == S_SS_ON) begin
            state_d = S_WAIT_TX;
          end else if (state_q == S_WR_TX) begin
            state_d = S_WAIT_RX;
          end else if (state_q == S_RD_RX) begin
            if (last_byte) begin
              state_d = S_SS_OFF;
            end else begin
              byte_d  = byte_q + 3'd1;
              state_d = S_WAIT_TX;
            end
          end else begin
            if (tmo_q) begin
              state_d = cfg_done_q ? S_IDLE : S_CFG;
            end else if (cfg_mode_q) begin
              cfg_done_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              state_d = S_PUBLISH;
            end
          end
        end
      end
      S_WAIT_TX, S_WAIT_RX: begin
        if ((state_q == S_WAIT_TX) ? readyfordata : dataavailable) begin
          ph_d    = 2'd0;
          state_d = (state_q == S_WAIT_TX) ? S_WR_TX : S_RD_RX;
        end else if (to_q == TO_LAST) begin
          error_d = 1'b1;
          tmo_d   = 1'b1;
          ph_d    = 2'd0;
          state_d = S_SS_OFF;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_PUBLISH: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Registered bus outputs decoded from the next state.
    acc_d = (state_d inside {S_SS_ON, S_WR_TX, S_RD_RX, S_SS_OFF}) && (ph_d != 2'd2);
    if (cfg_mode_d) tx_byte = (byte_d == 3'd0) ? 8'h20 : CTRL1_VAL;
    else            tx_byte = (byte_d == 3'd0) ? 8'hE8 : 8'h00;

    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    if (acc_d) begin
      case (state_d)
        S_SS_ON:  begin mem_addr_d = 3'd3; wdata_d = 16'h0400; end
        S_SS_OFF: begin mem_addr_d = 3'd3; wdata_d = 16'h0000; end
        S_WR_TX:  begin mem_addr_d = 3'd1; wdata_d = {8'h00, tx_byte}; end
        default:  begin mem_addr_d = 3'd0; wdata_d = 16'h0000; end
      endcase
    end
    read_n_d  = !(acc_d && state_d == S_RD_RX);
    write_n_d = !(acc_d && state_d != S_RD_RX);
    sel_d     = acc_d;

    busy_d  = !cfg_mode_d && !(state_d inside {S_CFG, S_IDLE, S_PUBLISH});
    valid_d = (state_d == S_PUBLISH);
    sx_d    = valid_d ? {rx_q[1], rx_q[0]} : sx_q;
    sy_d    = valid_d ? {rx_q[3], rx_q[2]} : sy_q;
    sz_d    = valid_d ? {rx_q[5], rx_q[4]} : sz_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CFG;
      ph_q       <= '0;
      byte_q     <= '0;
      to_q       <= '0;
      cnt_q      <= '0;
      cfg_mode_q <= 1'b1;
      tmo_q      <= 1'b0;
      rx_q       <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      read_n_q   <= 1'b1;
      write_n_q  <= 1'b1;
      sel_q      <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      sz_q       <= '0;
      valid_q    <= 1'b0;
      cfg_done_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      byte_q     <= byte_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      cfg_mode_q <= cfg_mode_d;
      tmo_q      <= tmo_d;
      rx_q       <= rx_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      read_n_q   <= read_n_d;
      write_n_q  <= write_n_d;
      sel_q      <= sel_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      sz_q       <= sz_d;
      valid_q    <= valid_d;
      cfg_done_q <= cfg_done_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign data_from_cpu = wdata_q;
  assign read_n        = read_n_q;
  assign write_n       = write_n_q;
  assign spi_select    = sel_q;
  assign sample_x      = sx_q;
  assign sample_y      = sy_q;
  assign sample_z      = sz_q;
  assign sample_valid  = valid_q;
  assign cfg_done      = cfg_done_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lis3dh_sampler.sv
// Bench for lis3dh_sampler: register-level model of the SPI core plus a
// LIS3DH slave that answers burst reads from a programmable frame.
module tb_lis3dh_sampler;

  localparam int SAMPLE_DIV = 600;
  localparam int TIMEOUT    = 4095;
  localparam int LAT        = 24;   // core cycles per byte

  logic        clk, reset, enable;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        read_n, write_n, spi_select, readyfordata, dataavailable;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid, cfg_done, busy, error;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_q[$];

  lis3dh_sampler #(
    .SAMPLE_DIV(SAMPLE_DIV), .CTRL1_VAL(8'h57), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
    .data_to_cpu(data_to_cpu), .readyfordata(readyfordata), .dataavailable(dataavailable),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_valid(sample_valid), .cfg_done(cfg_done), .busy(busy), .error(error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI core + LIS3DH slave model ----------------
  logic       rx_stall = 1'b0;
  logic [7:0] resp [6];
  logic       ss_n, in_flight, prev_wr, prev_rd;
  logic [7:0] tx_byte;
  int         lat_cnt, sl_idx;
  logic [7:0] sb [8];
  int         last_len = 0;
  logic [7:0] last_b0 = 8'h00;
  logic [7:0] last_b1 = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      readyfordata  <= 1'b1;
      dataavailable <= 1'b0;
      data_to_cpu   <= '0;
      ss_n          <= 1'b1;
      in_flight     <= 1'b0;
      prev_wr       <= 1'b1;
      prev_rd       <= 1'b1;
      tx_byte       <= '0;
      lat_cnt       <= 0;
      sl_idx        <= 0;
    end else begin
      prev_wr <= write_n;
      prev_rd <= read_n;
      if (spi_select && !write_n && prev_wr) begin
        if (mem_addr == 3'd3) begin
          if (!data_from_cpu[10] && !ss_n) begin
            last_len <= sl_idx;
            last_b0  <= sb[0];
            last_b1  <= sb[1];
          end
          ss_n <= !data_from_cpu[10];
          if (!data_from_cpu[10]) sl_idx <= 0;
        end else if (mem_addr == 3'd1) begin
          readyfordata <= 1'b0;
          tx_byte      <= data_from_cpu[7:0];
          lat_cnt      <= LAT;
          in_flight    <= 1'b1;
        end
      end
      if (in_flight) begin
        if (lat_cnt > 0) begin
          lat_cnt <= lat_cnt - 1;
        end else if (!rx_stall) begin
          in_flight     <= 1'b0;
          dataavailable <= 1'b1;
          data_to_cpu   <= {8'h00, (sl_idx >= 1 && sl_idx <= 6) ? resp[sl_idx-1] : 8'h00};
          if (sl_idx < 8) sb[sl_idx] <= tx_byte;
          sl_idx <= sl_idx + 1;
        end
      end
      if (read_n && !prev_rd && mem_addr == 3'd0) begin
        dataavailable <= 1'b0;
        readyfordata  <= 1'b1;
      end
    end
  end

  // ---------------- bus monitor + scoreboard ----------------
  int          cyc = 0;
  int          acc_len = 0;
  int          n_valid = 0;
  int          last_tx_cyc = 0;
  int          err_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_error = 1'b0;
  logic [2:0]  last_wr_addr = 3'd0;
  logic [15:0] last_wr_data = 16'h0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      acc_len    <= 0;
      prev_valid <= 1'b0;
      prev_error <= 1'b0;
    end else begin
      if (!read_n || !write_n) begin
        if (acc_len == 0) begin
          check("acc_strobe", {spi_select, read_n ^ write_n}, 2'b11);
          if (!write_n) begin
            last_wr_addr <= mem_addr;
            last_wr_data <= data_from_cpu;
            if (mem_addr == 3'd1) check("tx_ready", readyfordata, 1'b1);
          end
        end
        if (!write_n && mem_addr == 3'd1) last_tx_cyc <= cyc;
        acc_len <= acc_len + 1;
      end else if (acc_len != 0) begin
        check("acc_len", acc_len, 2);
        acc_len <= 0;
      end
      if (error && !prev_error) err_cyc <= cyc;
      if (sample_valid) begin
        n_valid <= n_valid + 1;
        check("valid_width", prev_valid, 1'b0);
        check("valid_busy", busy, 1'b0);
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("sample_xyz", {sample_x, sample_y, sample_z}, exp_q.pop_front());
      end
      prev_valid <= sample_valid;
      prev_error <= error;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // bytes[7:0] is the first byte after the dummy (XL).
  task automatic load_frame(input logic [47:0] bytes);
    for (int i = 0; i < 6; i++) resp[i] = bytes[8*i +: 8];
    exp_q.push_back({resp[1], resp[0], resp[3], resp[2], resp[5], resp[4]});
  endtask

  task automatic wait_valid(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_valid < target && k < budget) begin
      step(1);
      k++;
    end
    check(tag, n_valid, target);
  endtask

  task automatic wait_cfg(input int budget);
    int k;
    k = 0;
    while (!cfg_done && k < budget) begin
      step(1);
      k++;
    end
    check("cfg_done", cfg_done, 1'b1);
    check("cfg_len", last_len, 2);
    check("cfg_b0", last_b0, 8'h20);
    check("cfg_b1", last_b1, 8'h57);
    check("cfg_ss_off", ss_n, 1'b1);
    check("cfg_busy", busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, mem_addr, 3'd0);
    check({tag, "_wdata"}, data_from_cpu, 16'h0);
    check({tag, "_strobes"}, {spi_select, read_n, write_n}, 3'b011);
    check({tag, "_samples"}, {sample_x, sample_y, sample_z}, 48'h0);
    check({tag, "_flags"}, {sample_valid, cfg_done, busy, error}, 4'b0000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [47:0] frame;
    int k;
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) resp[i] = 8'h00;
    step(3);
    check_reset_values("rst");

    // Configuration, then first burst
    load_frame(48'h9ABC_5678_1234);
    reset = 1'b0;
    wait_cfg(2000);
    wait_valid("burst1", 1, 2 * SAMPLE_DIV);
    check("burst_len", last_len, 7);
    check("burst_b0", last_b0, 8'hE8);
    check("burst_b1", last_b1, 8'h00);
    check("burst_err", error, 1'b0);
    step(50);
    check("hold_x", sample_x, 16'h1234);
    check("hold_valid", sample_valid, 1'b0);

    load_frame(48'h0001_FFFF_8000);
    wait_valid("burst2", 2, 2 * SAMPLE_DIV);

    for (int i = 0; i < 2; i++) begin
      frame[31:0]  = $urandom;
      frame[47:32] = 16'($urandom_range(0, 65535));
      load_frame(frame);
      wait_valid("burst_rand", 3 + i, 2 * SAMPLE_DIV);
    end

    // enable dropped during byte 3: burst still publishes, then nothing
    load_frame(48'h7F00_0180_FE01);
    k = 0;
    while (!(busy && sl_idx >= 3) && k < 2 * SAMPLE_DIV) begin
      step(1);
      k++;
    end
    check("drop_midburst", busy, 1'b1);
    enable = 1'b0;
    wait_valid("burst_drop", 5, SAMPLE_DIV);
    step(2 * SAMPLE_DIV);
    check("no_burst_disabled", n_valid, 5);
    check("idle_busy", busy, 1'b0);

    // re-raise: a burst starts within one period
    enable = 1'b1;
    load_frame(48'h0102_0304_0506);
    k = 0;
    while (!busy && k < SAMPLE_DIV + 4) begin
      step(1);
      k++;
    end
    check("reenable_busy", busy, 1'b1);
    wait_valid("burst_reen", 6, SAMPLE_DIV);

    // reset in the middle of a burst; configuration re-runs
    k = 0;
    while (!(busy && sl_idx >= 2) && k < 2 * SAMPLE_DIV) begin
      step(1);
      k++;
    end
    check("rstmid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_values("rstmid");
    step(2);
    reset = 1'b0;
    load_frame(48'hCAFE_0000_7FFF);
    wait_cfg(2000);
    wait_valid("burst_after_rst", 7, 2 * SAMPLE_DIV);

    // RRDY never arrives: timeout, SSO off, no publish
    rx_stall = 1'b1;
    k = 0;
    while (!error && k < 2 * SAMPLE_DIV + TIMEOUT + 200) begin
      step(1);
      k++;
    end
    check("tmo_error", error, 1'b1);
    step(20);
    // one idle access cycle, TIMEOUT+1 wait cycles, then the flag registers
    check("tmo_cycles", err_cyc - last_tx_cyc, TIMEOUT + 3);
    check("tmo_ss_off", ss_n, 1'b1);
    check("tmo_ctrl_write", {last_wr_addr, last_wr_data}, {3'd3, 16'h0000});
    check("tmo_no_valid", n_valid, 7);
    check("tmo_cfg_kept", cfg_done, 1'b1);
    enable = 1'b0;
    step(SAMPLE_DIV);
    check("error_sticky", error, 1'b1);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
